// File: rtl/of_ex_skid_buffer_if.sv
// Valid/ready bundle link between Operand Fetch and Execute.
// The master drives the bundle and valid; the slave drives ready.
interface of_ex_skid_buffer_if #(
    parameter int PC_W   = 10,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] branch_target;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] op_2;
    logic [DATA_W-1:0] ir;

    modport master (
        output valid,
        output pc,
        output branch_target,
        output op_a,
        output op_b,
        output op_2,
        output ir,
        input  ready
    );

    modport slave (
        input  valid,
        input  pc,
        input  branch_target,
        input  op_a,
        input  op_b,
        input  op_2,
        input  ir,
        output ready
    );
endinterface

// File: rtl/of_ex_skid_buffer.sv
// Two-entry elastic OF->EX register with flush and a saturating OF stall counter.
// State advances on the falling clock edge; in_ready comes only from held state.
module of_ex_skid_buffer #(
    parameter int PC_W        = 10,
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    of_ex_skid_buffer_if.slave     in_if,
    of_ex_skid_buffer_if.master    out_if,
    input  logic                   flush,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_count
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] branch_target;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [DATA_W-1:0] op_2;
        logic [DATA_W-1:0] ir;
    } bundle_t;

    state_e  state_q, state_d;
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    bundle_t in_b;

    logic [STALL_CNT_W-1:0] stall_q;
    logic in_ready;
    logic out_valid;
    logic push;
    logic pop;
    logic stall;

    assign in_b = '{
        pc:            in_if.pc,
        branch_target: in_if.branch_target,
        op_a:          in_if.op_a,
        op_b:          in_if.op_b,
        op_2:          in_if.op_2,
        ir:            in_if.ir
    };

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_if.valid & in_ready;
    assign pop       = out_valid & out_if.ready;
    assign stall     = in_if.valid & ~in_ready;

    assign in_if.ready          = in_ready;
    assign out_if.valid         = out_valid;
    assign out_if.pc            = main_q.pc;
    assign out_if.branch_target = main_q.branch_target;
    assign out_if.op_a          = main_q.op_a;
    assign out_if.op_b          = main_q.op_b;
    assign out_if.op_2          = main_q.op_2;
    assign out_if.ir            = main_q.ir;
    assign stall_count          = stall_q;

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Flush only drops the valid state; the data registers keep their contents.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_d  = in_b;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    unique case (1'b1)
                        push & pop: main_d = in_b;
                        push & ~pop: begin
                            skid_d  = in_b;
                            state_d = FULL;
                        end
                        pop & ~push: state_d = EMPTY;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (stall && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_of_ex_skid_buffer.sv
// Bench for of_ex_skid_buffer: queue model checked every cycle plus directed literals.
// A second narrow-counter instance exercises stall_count saturation.
module tb_of_ex_skid_buffer;
    typedef struct packed {
        logic [9:0]  pc;
        logic [31:0] bt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] o2;
        logic [31:0] ir;
    } bun_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush;
    logic sat_flush;
    logic [1:0]  occupancy;
    logic [15:0] stall_count;
    logic [1:0]  sat_occ;
    logic [3:0]  sat_stall;

    int checks = 0;
    int failures = 0;
    bit run = 1'b0;

    bun_t q[$];
    int   m_stall = 0;

    of_ex_skid_buffer_if #(.PC_W(10), .DATA_W(32)) in_if ();
    of_ex_skid_buffer_if #(.PC_W(10), .DATA_W(32)) out_if ();
    of_ex_skid_buffer_if #(.PC_W(10), .DATA_W(32)) sat_in ();
    of_ex_skid_buffer_if #(.PC_W(10), .DATA_W(32)) sat_out ();

    of_ex_skid_buffer #(.PC_W(10), .DATA_W(32), .STALL_CNT_W(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_if(in_if.slave),
        .out_if(out_if.master),
        .flush(flush),
        .occupancy(occupancy),
        .stall_count(stall_count)
    );

    of_ex_skid_buffer #(.PC_W(10), .DATA_W(32), .STALL_CNT_W(4)) dut_sat (
        .clk(clk),
        .rst_n(rst_n),
        .in_if(sat_in.slave),
        .out_if(sat_out.master),
        .flush(sat_flush),
        .occupancy(sat_occ),
        .stall_count(sat_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic bun_t in_bun();
        return {in_if.pc, in_if.branch_target, in_if.op_a,
                in_if.op_b, in_if.op_2, in_if.ir};
    endfunction

    function automatic bun_t out_bun();
        return {out_if.pc, out_if.branch_target, out_if.op_a,
                out_if.op_b, out_if.op_2, out_if.ir};
    endfunction

    function automatic bun_t mk(input logic [9:0] pc);
        bun_t r;
        r.pc = pc;
        r.bt = 32'h1000 + 32'(pc);
        r.a  = 32'hA000_0000 | 32'(pc);
        r.b  = 32'hB000_0000 ^ 32'(pc);
        r.o2 = 32'(pc) * 3;
        r.ir = 32'h0000_0013 | (32'(pc) << 20);
        return r;
    endfunction

    // Model: the buffer is a FIFO of at most two bundles.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_stall = 0;
        end else begin
            bit rdy, push, pop;
            rdy  = q.size() < 2;
            push = in_if.valid && rdy;
            pop  = (q.size() > 0) && out_if.ready;
            if (in_if.valid && !rdy && m_stall != 65535) m_stall++;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(in_bun());
            end
        end
    end

    always @(posedge clk) begin
        if (run && rst_n) begin
            chk("cmp_in_ready", in_if.ready, q.size() < 2);
            chk("cmp_out_valid", out_if.valid, q.size() != 0);
            chk("cmp_occupancy", occupancy, q.size());
            chk("cmp_stall_count", stall_count, m_stall);
            if (q.size() != 0) chk("cmp_head", out_bun(), q[0]);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input bun_t b);
        in_if.valid = v;
        {in_if.pc, in_if.branch_target, in_if.op_a,
         in_if.op_b, in_if.op_2, in_if.ir} = b;
    endtask

    bun_t xb;

    initial begin
        xb = '{pc: 10'h3FF, bt: 32'h3FC, a: 32'h1, b: 32'hFFFF_FFFF,
               o2: 32'h7, ir: 32'hDEAD_BEEF};
        drv(1'b0, '0);
        out_if.ready = 1'b0;
        flush = 1'b0;
        sat_flush = 1'b0;
        sat_in.valid = 1'b1;
        {sat_in.pc, sat_in.branch_target, sat_in.op_a,
         sat_in.op_b, sat_in.op_2, sat_in.ir} = '0;
        sat_out.ready = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_if.ready, 1'b1);
        chk("rst_out_valid", out_if.valid, 1'b0);
        chk("rst_occupancy", occupancy, 2'd0);
        chk("rst_stall", stall_count, 16'd0);
        chk("rst_out_data", out_bun(), '0);
        #10 rst_n = 1'b1;
        run = 1'b1;

        // Streaming
        out_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, mk(10'(i * 4)));
            step();
            chk("stream_pc", out_if.pc, 10'(i * 4));
            chk("stream_occ", occupancy, 2'd1);
        end
        drv(1'b0, '0);
        step();
        chk("stream_stall", stall_count, 16'd0);
        chk("stream_drain_occ", occupancy, 2'd0);

        // Backpressure
        out_if.ready = 1'b0;
        drv(1'b1, mk(10'h10));
        step();
        drv(1'b1, mk(10'h14));
        step();
        chk("bp_occ", occupancy, 2'd2);
        chk("bp_in_ready", in_if.ready, 1'b0);
        drv(1'b1, mk(10'h18));
        for (int i = 0; i < 3; i++) step();
        chk("bp_stall", stall_count, 16'd3);
        chk("bp_head", out_if.pc, 10'h10);
        out_if.ready = 1'b1;
        drv(1'b0, '0);
        step();
        chk("bp_pop1", out_if.pc, 10'h14);
        chk("bp_ready_back", in_if.ready, 1'b1);
        drv(1'b1, mk(10'h18));
        step();
        chk("bp_pop2", out_if.pc, 10'h18);
        chk("bp_occ1", occupancy, 2'd1);
        drv(1'b0, '0);
        step();
        chk("bp_empty", out_if.valid, 1'b0);

        // Flush with simultaneous push and pop
        out_if.ready = 1'b0;
        drv(1'b1, mk(10'h20));
        step();
        drv(1'b1, mk(10'h24));
        step();
        chk("fl_full", occupancy, 2'd2);
        drv(1'b1, mk(10'h28));
        out_if.ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        drv(1'b0, '0);
        chk("fl_occ", occupancy, 2'd0);
        chk("fl_valid", out_if.valid, 1'b0);
        chk("fl_ready", in_if.ready, 1'b1);
        chk("fl_stall", stall_count, 16'd4);
        step();
        chk("fl_no_28", out_if.valid, 1'b0);

        // Data integrity: direct then via skid
        drv(1'b1, xb);
        step();
        chk("int_direct", out_bun(), xb);
        drv(1'b0, '0);
        step();
        out_if.ready = 1'b0;
        drv(1'b1, mk(10'h001));
        step();
        drv(1'b1, xb);
        step();
        chk("int_full", occupancy, 2'd2);
        chk("int_main", out_if.pc, 10'h001);
        drv(1'b0, '0);
        out_if.ready = 1'b1;
        step();
        chk("int_skid", out_bun(), xb);
        step();
        chk("int_drained", occupancy, 2'd0);

        // Saturation on the narrow counter
        out_if.ready = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_stall", sat_stall, 4'hF);
        chk("sat_occ", sat_occ, 2'd2);

        // Asynchronous reset while FULL
        out_if.ready = 1'b0;
        drv(1'b1, mk(10'h30));
        step();
        drv(1'b1, mk(10'h34));
        step();
        chk("ar_full", occupancy, 2'd2);
        drv(1'b0, '0);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_occ", occupancy, 2'd0);
        chk("ar_valid", out_if.valid, 1'b0);
        chk("ar_ready", in_if.ready, 1'b1);
        chk("ar_stall", stall_count, 16'd0);
        chk("ar_data", out_bun(), '0);
        chk("ar_sat_stall", sat_stall, 4'd0);
        #1 rst_n = 1'b1;
        out_if.ready = 1'b1;
        drv(1'b1, mk(10'h40));
        step();
        chk("ar_push_valid", out_if.valid, 1'b1);
        chk("ar_push_data", out_bun(), mk(10'h40));
        drv(1'b0, '0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
